// File: rtl/dm_responder.sv
// Data-memory responder: word-organised SRAM with byte-lane writes, a fixed-latency
// read pipeline with a valid strobe, and out-of-range flagging for the core's DM port.
module dm_responder #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned RD_LAT = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_DM_CS,
  input  logic [3:0]  i_DM_WEB,
  input  logic [31:0] i_DM_addr,
  input  logic [31:0] i_DM_DI,
  output logic [31:0] o_DM_DO,
  output logic        o_DM_valid,
  output logic        o_DM_err
);

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("dm_responder: RD_LAT must be in 1..4");
  end
  if (ADDR_W < 1 || ADDR_W > 30) begin : g_bad_addr_w
    $error("dm_responder: ADDR_W must be in 1..30");
  end

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] word_idx;
  logic              out_of_range;
  logic              is_read;
  logic              do_write;
  logic              in_v;
  logic              in_e;
  logic [31:0]       in_d;
  logic              addr_lsb_unused;

  logic              pipe_v [RD_LAT];
  logic              pipe_e [RD_LAT];
  logic [31:0]       pipe_d [RD_LAT];

  assign word_idx        = i_DM_addr[ADDR_W+1:2];
  assign addr_lsb_unused = ^i_DM_addr[1:0];

  always_comb begin
    out_of_range = (i_DM_addr >> (ADDR_W + 2)) != '0;
    is_read      = i_DM_CS && (i_DM_WEB == 4'b1111);
    do_write     = i_DM_CS && (i_DM_WEB != 4'b1111) && !out_of_range;
    in_v         = is_read;
    in_e         = i_DM_CS && out_of_range;
    in_d         = out_of_range ? '0 : mem[word_idx];
  end

  // Array is deliberately not reset; contents survive i_rst_n.
  always_ff @(posedge i_clk) begin
    if (do_write) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (!i_DM_WEB[k]) mem[word_idx][8*k +: 8] <= i_DM_DI[8*k +: 8];
      end
    end
  end

  // Data only advances behind a valid read, so the last stage holds the previous
  // read value while invalid or error-only slots pass through.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_e[i] <= 1'b0;
        pipe_d[i] <= '0;
      end
    end else begin
      pipe_v[0] <= in_v;
      pipe_e[0] <= in_e;
      if (in_v) pipe_d[0] <= in_d;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_e[i] <= pipe_e[i-1];
        if (pipe_v[i-1]) pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  assign o_DM_valid = pipe_v[RD_LAT-1];
  assign o_DM_err   = pipe_e[RD_LAT-1];
  assign o_DM_DO    = pipe_d[RD_LAT-1];

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: three instances (RD_LAT 1, 3, 4) share stimulus;
// expected responses are queued at issue time and matched as they emerge.
module tb_dm_responder;

  localparam int NDUT = 3;
  localparam int LATS [NDUT] = '{1, 3, 4};

  typedef struct {
    int          due;
    logic        valid;
    logic        err;
    logic [31:0] data;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs;
  logic [3:0]  web;
  logic [31:0] addr;
  logic [31:0] di;
  logic [31:0] dout [NDUT];
  logic        vld  [NDUT];
  logic        err  [NDUT];

  sb_t         sbq [NDUT][$];
  logic [31:0] last_do [NDUT];
  logic [31:0] mdl [int];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dm_responder #(.ADDR_W(14), .RD_LAT(1)) u_lat1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_DM_CS(cs), .i_DM_WEB(web), .i_DM_addr(addr),
    .i_DM_DI(di), .o_DM_DO(dout[0]), .o_DM_valid(vld[0]), .o_DM_err(err[0])
  );
  dm_responder #(.ADDR_W(14), .RD_LAT(3)) u_lat3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_DM_CS(cs), .i_DM_WEB(web), .i_DM_addr(addr),
    .i_DM_DI(di), .o_DM_DO(dout[1]), .o_DM_valid(vld[1]), .o_DM_err(err[1])
  );
  dm_responder #(.ADDR_W(14), .RD_LAT(4)) u_lat4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_DM_CS(cs), .i_DM_WEB(web), .i_DM_addr(addr),
    .i_DM_DI(di), .o_DM_DO(dout[2]), .o_DM_valid(vld[2]), .o_DM_err(err[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic mon(input int d, input logic v, input logic e, input logic [31:0] o);
    sb_t x;
    string p;
    p = $sformatf("L%0d_", LATS[d]);
    if (v || e) begin
      if (sbq[d].size() == 0) begin
        check({p, "spurious"}, {30'b0, v, e}, 32'd0);
      end else begin
        x = sbq[d].pop_front();
        check({p, "due"}, cyc, x.due);
        check({p, "valid"}, {31'b0, v}, {31'b0, x.valid});
        check({p, "err"}, {31'b0, e}, {31'b0, x.err});
        if (x.valid) begin
          check({p, "data"}, o, x.data);
          last_do[d] = x.data;
        end
      end
    end
    if (!v) check({p, "hold"}, o, last_do[d]);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < NDUT; d++) mon(d, vld[d], err[d], dout[d]);
    end
  end

  task automatic push_all(input sb_t x);
    sb_t y;
    for (int d = 0; d < NDUT; d++) begin
      y = x;
      y.due = cyc + LATS[d];
      sbq[d].push_back(y);
    end
  endtask

  task automatic req(input logic [3:0] w, input logic [31:0] a, input logic [31:0] dv);
    sb_t         x;
    logic        oor;
    int          idx;
    logic [31:0] cur;
    @(posedge clk); #1;
    cs = 1'b1; web = w; addr = a; di = dv;
    oor = (a[31:16] != 16'h0);
    idx = int'(a[15:2]);
    if (w == 4'b1111) begin
      x.valid = 1'b1;
      x.err   = oor;
      x.data  = oor ? 32'h0 : (mdl.exists(idx) ? mdl[idx] : 32'h0);
      push_all(x);
    end else if (oor) begin
      x.valid = 1'b0;
      x.err   = 1'b1;
      x.data  = 32'h0;
      push_all(x);
    end else begin
      cur = mdl.exists(idx) ? mdl[idx] : 32'h0;
      for (int k = 0; k < 4; k++) if (!w[k]) cur[8*k +: 8] = dv[8*k +: 8];
      mdl[idx] = cur;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      cs = 1'b0; web = 4'b1111;
    end
  endtask

  task automatic check_reset_outputs();
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("L%0d_rst_do", LATS[d]), dout[d], 32'h0);
      check($sformatf("L%0d_rst_valid", LATS[d]), {31'b0, vld[d]}, 32'h0);
      check($sformatf("L%0d_rst_err", LATS[d]), {31'b0, err[d]}, 32'h0);
    end
  endtask

  // Reset asserted just after an edge kills everything not yet sampled.
  task automatic pulse_reset();
    @(posedge clk); #1;
    cs = 1'b0; web = 4'b1111; rst_n = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      sbq[d].delete();
      last_do[d] = 32'h0;
    end
    #1;
    check_reset_outputs();
    idle(2);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  w;
    rst_n = 1'b0; cs = 1'b0; web = 4'b1111; addr = '0; di = '0;
    for (int d = 0; d < NDUT; d++) last_do[d] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Preload words 0..8
    for (int i = 0; i < 8; i++) req(4'b0000, 32'(i * 4), 32'(i + 1));
    req(4'b0000, 32'h20, 32'hA5A5A5A5);

    // Full word then byte lanes
    req(4'b0000, 32'h10, 32'hDEADBEEF);
    req(4'b1111, 32'h10, 32'h0);
    req(4'b1011, 32'h12, 32'h55555555);
    req(4'b1111, 32'h10, 32'h0);
    req(4'b0011, 32'h10, 32'h12341234);
    req(4'b1111, 32'h10, 32'h0);
    idle(5);

    // Back-to-back pipelined reads
    for (int i = 0; i < 4; i++) req(4'b1111, 32'(i * 4), 32'h0);
    idle(5);

    // Snapshot ordering
    req(4'b1111, 32'h20, 32'h0);
    req(4'b0000, 32'h20, 32'h0);
    req(4'b1111, 32'h20, 32'h0);
    idle(5);

    // Out of range read and write; word 0 must survive
    req(4'b1111, 32'h00010000, 32'h0);
    req(4'b0000, 32'h00010000, 32'hFFFFFFFF);
    req(4'b1111, 32'h0, 32'h0);
    req(4'b1111, 32'hFFFFFFFC, 32'h0);
    idle(5);

    // Non-contiguous mask and top in-range word
    req(4'b0101, 32'h4, 32'hAABBCCDD);
    req(4'b1111, 32'h4, 32'h0);
    req(4'b0000, 32'h0000FFFC, 32'h600DF00D);
    req(4'b1111, 32'h0000FFFC, 32'h0);
    idle(5);

    // Random mix over preloaded words
    for (int n = 0; n < 60; n++) begin
      a = 32'($urandom_range(0, 8) * 4);
      if ($urandom_range(0, 7) == 0) a[31:16] = 16'($urandom_range(1, 65535));
      if ($urandom_range(0, 1) == 1) w = 4'b1111;
      else w = 4'($urandom_range(0, 14));
      if ($urandom_range(0, 5) == 0) idle(1);
      else req(w, a, $urandom);
    end
    idle(6);

    // Reset with reads in flight, then confirm array contents survived
    req(4'b0000, 32'h10, 32'hCAFEF00D);
    req(4'b1111, 32'h10, 32'h0);
    req(4'b1111, 32'h14, 32'h0);
    pulse_reset();
    idle(6);
    req(4'b1111, 32'h10, 32'h0);
    req(4'b1111, 32'h14, 32'h0);
    idle(8);

    for (int d = 0; d < NDUT; d++)
      check($sformatf("L%0d_drain", LATS[d]), 32'(sbq[d].size()), 32'h0);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
